xfer_seq: RTL and testbench

XFER_SEQ -- requirements
Module: xfer_seq

---
 rtl/xfer_seq.sv | 212 +++++++++++++++++++++
 tb/tb_xfer_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xfer_seq.sv
// Byte/word transfer sequencer between a transfer register and memory.
// Every strobe and status output is registered from the next state.
module xfer_seq #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        dir,
    input  logic        word,
    input  logic [15:0] addr_in,
    input  logic        mem_rdy,
    output logic        l_tl_n,
    output logic        l_th_n,
    output logic        a_tl_n,
    output logic        a_th_n,
    output logic        a_tx_addr_n,
    output logic        mem_rd_n,
    output logic        mem_wr_n,
    output logic [15:0] mem_addr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        LO_WAIT,
        LO_LATCH,
        GAP,
        HI_WAIT,
        HI_LATCH,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

    state_t      state;
    state_t      state_nx;
    logic        dir_q;
    logic        word_q;
    logic [15:0] base;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nx;
    logic        in_wait;
    logic        timeout;

    logic        l_tl_d;
    logic        l_th_d;
    logic        a_tl_d;
    logic        a_th_d;
    logic        a_tx_d;
    logic        rd_d;
    logic        wr_d;
    logic [15:0] addr_d;
    logic        busy_d;
    logic        done_d;
    logic        err_d;

    assign in_wait = (state == LO_WAIT) || (state == HI_WAIT);
    assign timeout = !mem_rdy && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            dir_q  <= 1'b0;
            word_q <= 1'b0;
            base   <= 16'h0000;
            cnt    <= 8'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && start) begin
                dir_q  <= dir;
                word_q <= word;
            end
            if (state == ADDR) begin
                base <= addr_in;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ADDR;
                end
            end
            ADDR: state_nx = LO_WAIT;
            LO_WAIT: begin
                if (mem_rdy) begin
                    if (!dir_q) begin
                        state_nx = LO_LATCH;
                    end else if (word_q) begin
                        state_nx = GAP;
                    end else begin
                        state_nx = DONE;
                    end
                end else if (timeout) begin
                    state_nx = ERR;
                end
            end
            LO_LATCH: state_nx = word_q ? GAP : DONE;
            GAP:      state_nx = HI_WAIT;
            HI_WAIT: begin
                if (mem_rdy) begin
                    state_nx = dir_q ? DONE : HI_LATCH;
                end else if (timeout) begin
                    state_nx = ERR;
                end
            end
            HI_LATCH: state_nx = DONE;
            DONE:     state_nx = IDLE;
            ERR:      state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // The counter only runs across consecutive not-ready WAIT cycles.
    always_comb begin
        cnt_nx = 8'd0;
        if (in_wait && !mem_rdy) begin
            cnt_nx = cnt + 8'd1;
        end
    end

    always_comb begin
        l_tl_d = 1'b1;
        l_th_d = 1'b1;
        a_tl_d = 1'b1;
        a_th_d = 1'b1;
        a_tx_d = 1'b1;
        rd_d   = 1'b1;
        wr_d   = 1'b1;
        busy_d = (state_nx != IDLE);
        done_d = 1'b0;
        err_d  = 1'b0;
        unique case (state_nx)
            ADDR: a_tx_d = 1'b0;
            LO_WAIT: begin
                if (dir_q) begin
                    wr_d   = 1'b0;
                    a_tl_d = 1'b0;
                end else begin
                    rd_d = 1'b0;
                end
            end
            HI_WAIT: begin
                if (dir_q) begin
                    wr_d   = 1'b0;
                    a_th_d = 1'b0;
                end else begin
                    rd_d = 1'b0;
                end
            end
            LO_LATCH: begin
                rd_d   = 1'b0;
                l_tl_d = 1'b0;
            end
            HI_LATCH: begin
                rd_d   = 1'b0;
                l_th_d = 1'b0;
            end
            DONE:    done_d = 1'b1;
            ERR:     err_d  = 1'b1;
            default: ;
        endcase
    end

    // Address is loaded on the way into each WAIT state and held otherwise.
    always_comb begin
        addr_d = mem_addr;
        if (state == ADDR) begin
            addr_d = addr_in;
        end else if (state == GAP) begin
            addr_d = base + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_tl_n      <= 1'b1;
            l_th_n      <= 1'b1;
            a_tl_n      <= 1'b1;
            a_th_n      <= 1'b1;
            a_tx_addr_n <= 1'b1;
            mem_rd_n    <= 1'b1;
            mem_wr_n    <= 1'b1;
            mem_addr    <= 16'h0000;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            l_tl_n      <= l_tl_d;
            l_th_n      <= l_th_d;
            a_tl_n      <= a_tl_d;
            a_th_n      <= a_th_d;
            a_tx_addr_n <= a_tx_d;
            mem_rd_n    <= rd_d;
            mem_wr_n    <= wr_d;
            mem_addr    <= addr_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
        end
    end

endmodule

// File: tb/tb_xfer_seq.sv
// Directed bench for xfer_seq: load/store, byte/word, wrap,
// timeout, mid-transfer reset and ignored start.
module tb_xfer_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic        word = 1'b0;
    logic [15:0] addr_in = 16'h0000;
    logic        mem_rdy = 1'b0;
    logic        l_tl_n;
    logic        l_th_n;
    logic        a_tl_n;
    logic        a_th_n;
    logic        a_tx_addr_n;
    logic        mem_rd_n;
    logic        mem_wr_n;
    logic [15:0] mem_addr;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int fails = 0;

    int n_atx, n_rd, n_wr, n_tl, n_th, n_ltl, n_lth;
    int n_multi, n_busy_lo, n_th_bad;
    int done_cyc, err_cyc;
    logic [15:0] addr_first, addr_last;
    bit seen_addr;

    xfer_seq #(.WAIT_MAX(15)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dir(dir),
        .word(word),
        .addr_in(addr_in),
        .mem_rdy(mem_rdy),
        .l_tl_n(l_tl_n),
        .l_th_n(l_th_n),
        .a_tl_n(a_tl_n),
        .a_th_n(a_th_n),
        .a_tx_addr_n(a_tx_addr_n),
        .mem_rd_n(mem_rd_n),
        .mem_wr_n(mem_wr_n),
        .mem_addr(mem_addr),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    // Runs one transfer from a negedge; memory is ready after nlow
    // wait cycles; start is pulsed again at cycle pulse_at.
    task automatic collect(input int nlow, input int budget,
                           input int pulse_at);
        int wcnt;
        bit in_wait;
        n_atx = 0; n_rd = 0; n_wr = 0; n_tl = 0; n_th = 0;
        n_ltl = 0; n_lth = 0; n_multi = 0; n_busy_lo = 0;
        n_th_bad = 0; done_cyc = 0; err_cyc = 0;
        seen_addr = 0; addr_first = 16'hxxxx; addr_last = 16'hxxxx;
        wcnt = 0;
        start = 1'b1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            start = (i == pulse_at);
            if (!a_tx_addr_n) n_atx++;
            if (!mem_rd_n) n_rd++;
            if (!mem_wr_n) n_wr++;
            if (!a_tl_n) n_tl++;
            if (!a_th_n) n_th++;
            if (!l_tl_n) n_ltl++;
            if (!l_th_n) n_lth++;
            if (!a_th_n && mem_wr_n) n_th_bad++;
            if (!busy) n_busy_lo++;
            if ($countones({l_tl_n, l_th_n, a_tl_n, a_th_n,
                            a_tx_addr_n}) < 4) n_multi++;
            if (!mem_rd_n || !mem_wr_n) begin
                if (!seen_addr) addr_first = mem_addr;
                seen_addr = 1;
                addr_last = mem_addr;
            end
            in_wait = (!mem_rd_n || !mem_wr_n) && l_tl_n && l_th_n;
            if (in_wait) begin
                mem_rdy = (wcnt >= nlow);
                wcnt++;
            end else begin
                wcnt = 0;
                mem_rdy = 1'b0;
            end
            if (done) begin
                done_cyc = i;
                break;
            end
            if (err) begin
                err_cyc = i;
                break;
            end
        end
        start = 1'b0;
        mem_rdy = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({l_tl_n, l_th_n, a_tl_n, a_th_n, a_tx_addr_n,
             mem_rd_n, mem_wr_n} !== 7'h7f) begin
            fails++;
            $display("FAIL reset_strobes got=%b want=1111111",
                     {l_tl_n, l_th_n, a_tl_n, a_th_n, a_tx_addr_n,
                      mem_rd_n, mem_wr_n});
        end
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            fails++;
            $display("FAIL reset_status got=%b want=000",
                     {busy, done, err});
        end
        checks++;
        if (mem_addr !== 16'h0000) begin
            fails++;
            $display("FAIL reset_addr got=%h want=0000", mem_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_load;
        dir = 1'b0; word = 1'b1; addr_in = 16'h1234;
        collect(0, 20, 0);
        checks++;
        if (done_cyc !== 7) begin
            fails++;
            $display("FAIL wl_done_cycle got=%0d want=7", done_cyc);
        end
        checks++;
        if (n_atx !== 1) begin
            fails++;
            $display("FAIL wl_atx got=%0d want=1", n_atx);
        end
        checks++;
        if (addr_first !== 16'h1234 || addr_last !== 16'h1235) begin
            fails++;
            $display("FAIL wl_addr got=%h/%h want=1234/1235",
                     addr_first, addr_last);
        end
        checks++;
        if (n_ltl !== 1 || n_lth !== 1) begin
            fails++;
            $display("FAIL wl_latch got=%0d/%0d want=1/1", n_ltl, n_lth);
        end
        checks++;
        if (n_rd !== 4 || n_wr !== 0) begin
            fails++;
            $display("FAIL wl_rdwr got=%0d/%0d want=4/0", n_rd, n_wr);
        end
        checks++;
        if (n_multi !== 0 || n_busy_lo !== 0) begin
            fails++;
            $display("FAIL wl_multi_busy got=%0d/%0d want=0/0",
                     n_multi, n_busy_lo);
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            fails++;
            $display("FAIL wl_idle got=%b want=00", {busy, done});
        end
    endtask

    task automatic test_byte_store;
        dir = 1'b1; word = 1'b0; addr_in = 16'h00a5;
        collect(3, 20, 0);
        checks++;
        if (done_cyc !== 6) begin
            fails++;
            $display("FAIL bs_done_cycle got=%0d want=6", done_cyc);
        end
        checks++;
        if (n_wr !== 4 || n_tl !== 4) begin
            fails++;
            $display("FAIL bs_wr_tl got=%0d/%0d want=4/4", n_wr, n_tl);
        end
        checks++;
        if (n_th !== 0 || n_rd !== 0 || n_ltl !== 0) begin
            fails++;
            $display("FAIL bs_no_hi got=%0d/%0d/%0d want=0/0/0",
                     n_th, n_rd, n_ltl);
        end
        checks++;
        if (addr_first !== 16'h00a5 || addr_last !== 16'h00a5) begin
            fails++;
            $display("FAIL bs_addr got=%h/%h want=00a5/00a5",
                     addr_first, addr_last);
        end
        @(negedge clk);
    endtask

    task automatic test_word_store_wrap;
        dir = 1'b1; word = 1'b1; addr_in = 16'hffff;
        collect(0, 20, 0);
        checks++;
        if (done_cyc !== 5) begin
            fails++;
            $display("FAIL ws_done_cycle got=%0d want=5", done_cyc);
        end
        checks++;
        if (addr_first !== 16'hffff || addr_last !== 16'h0000) begin
            fails++;
            $display("FAIL ws_wrap got=%h/%h want=ffff/0000",
                     addr_first, addr_last);
        end
        checks++;
        if (n_th !== 1 || n_th_bad !== 0 || n_tl !== 1) begin
            fails++;
            $display("FAIL ws_assert got=%0d/%0d/%0d want=1/0/1",
                     n_th, n_th_bad, n_tl);
        end
        checks++;
        if (n_wr !== 2 || n_multi !== 0) begin
            fails++;
            $display("FAIL ws_wr got=%0d/%0d want=2/0", n_wr, n_multi);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        dir = 1'b0; word = 1'b0; addr_in = 16'h0300;
        collect(1000, 40, 0);
        checks++;
        if (err_cyc !== 17 || done_cyc !== 0) begin
            fails++;
            $display("FAIL to_err_cycle got=%0d/%0d want=17/0",
                     err_cyc, done_cyc);
        end
        checks++;
        if (n_rd !== 15) begin
            fails++;
            $display("FAIL to_rd_cycles got=%0d want=15", n_rd);
        end
        checks++;
        if (n_ltl !== 0 || n_lth !== 0) begin
            fails++;
            $display("FAIL to_no_latch got=%0d/%0d want=0/0",
                     n_ltl, n_lth);
        end
        @(negedge clk);
        checks++;
        if ({busy, err} !== 2'b00) begin
            fails++;
            $display("FAIL to_err_len got=%b want=00", {busy, err});
        end
    endtask

    task automatic test_reset_mid;
        dir = 1'b0; word = 1'b1; addr_in = 16'h4000;
        mem_rdy = 1'b1;
        start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        mem_rdy = 1'b0;
        checks++;
        if (mem_rd_n !== 1'b0 || mem_addr !== 16'h4001 ||
            l_th_n !== 1'b1) begin
            fails++;
            $display("FAIL rm_hi_wait got=%b/%h/%b want=0/4001/1",
                     mem_rd_n, mem_addr, l_th_n);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({l_tl_n, l_th_n, a_tl_n, a_th_n, a_tx_addr_n,
             mem_rd_n, mem_wr_n, busy} !== 8'hfe ||
            mem_addr !== 16'h0000) begin
            fails++;
            $display("FAIL rm_async got=%b/%h want=11111110/0000",
                     {l_tl_n, l_th_n, a_tl_n, a_th_n, a_tx_addr_n,
                      mem_rd_n, mem_wr_n, busy}, mem_addr);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || l_th_n !== 1'b1) begin
            fails++;
            $display("FAIL rm_idle got=%b/%b want=0/1", busy, l_th_n);
        end
        dir = 1'b0; word = 1'b0; addr_in = 16'h0055;
        collect(1, 20, 0);
        checks++;
        if (done_cyc !== 5 || n_ltl !== 1 || addr_last !== 16'h0055) begin
            fails++;
            $display("FAIL rm_restart got=%0d/%0d/%h want=5/1/0055",
                     done_cyc, n_ltl, addr_last);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored;
        dir = 1'b0; word = 1'b1; addr_in = 16'h2000;
        collect(0, 20, 3);
        checks++;
        if (done_cyc !== 7 || n_ltl !== 1 || n_lth !== 1) begin
            fails++;
            $display("FAIL si_done got=%0d/%0d/%0d want=7/1/1",
                     done_cyc, n_ltl, n_lth);
        end
        checks++;
        if (addr_first !== 16'h2000 || addr_last !== 16'h2001) begin
            fails++;
            $display("FAIL si_addr got=%h/%h want=2000/2001",
                     addr_first, addr_last);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || a_tx_addr_n !== 1'b1) begin
            fails++;
            $display("FAIL si_no_retrigger got=%b/%b want=0/1",
                     busy, a_tx_addr_n);
        end
    endtask

    initial begin
        test_reset;
        test_word_load;
        test_byte_store;
        test_word_store_wrap;
        test_timeout;
        test_reset_mid;
        test_start_ignored;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
